// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared RISC-V definitions for the upper-immediate decode path:
//   - major opcodes for LUI / AUIPC
//   - ALU-control encodings for LUI / AUIPC (replace the old backtick macros)
//   - upimm_entry_t: one fully decoded upper-immediate instruction
// Packages cannot take parameters, so the XLEN-dependent fields are sized to
// the widest supported XLEN; narrower datapaths use the low XLEN bits and the
// decoder leaves the upper bits at zero.
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN_MAX = 64;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // Any non-zero pair works; 5'd0 is reserved for "illegal / no operation".
  localparam logic [4:0] ALU_LUI   = 5'b01011;
  localparam logic [4:0] ALU_AUIPC = 5'b01100;

  typedef struct packed {
    logic [4:0]          rd;
    logic [XLEN_MAX-1:0] imm;
    logic [XLEN_MAX-1:0] result;
    logic [4:0]          alu_control;
    logic                wen;
    logic                illegal;
  } upimm_entry_t;

  function automatic logic is_upimm(input logic [6:0] opcode);
    return (opcode == OP_LUI) || (opcode == OP_AUIPC);
  endfunction

endpackage

// File: rtl/upimm_decode.sv
// -----------------------------------------------------------------------------
// upimm_decode
// Purely combinational decode of one instruction word plus its PC into an
// upimm_entry_t. Upper XLEN_MAX-XLEN bits of imm/result are driven to zero.
// Ports:
//   in_instr  [31:0]     instruction word
//   in_pc     [XLEN-1:0] PC of in_instr
//   entry                decoded entry (rd, imm, result, alu_control, wen, illegal)
// -----------------------------------------------------------------------------
module upimm_decode
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit ADD_PC = 1'b1
) (
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output upimm_entry_t    entry
);

  // Keeps only the live XLEN bits of a XLEN_MAX-wide value.
  localparam logic [XLEN_MAX-1:0] XMASK = (XLEN >= XLEN_MAX) ? {XLEN_MAX{1'b1}}
                                                              : ((XLEN_MAX'(1) << XLEN) - XLEN_MAX'(1));

  logic [6:0]          opcode;
  logic                legal;
  logic [XLEN_MAX-1:0] imm_full;
  logic [XLEN_MAX-1:0] pc_full;
  logic [XLEN_MAX-1:0] sum_full;

  always_comb begin
    opcode   = in_instr[6:0];
    legal    = is_upimm(opcode);
    // Sign-extend from instr[31]; masking afterwards gives the 32-bit form.
    imm_full = {{(XLEN_MAX-32){in_instr[31]}}, in_instr[31:12], 12'd0} & XMASK;
    pc_full  = XLEN_MAX'(in_pc);
    // Carry out of bit XLEN-1 is discarded by the mask.
    sum_full = (pc_full + imm_full) & XMASK;

    entry.rd          = in_instr[11:7];
    entry.imm         = imm_full;
    entry.illegal     = !legal;
    entry.wen         = legal && (in_instr[11:7] != 5'd0);
    entry.result      = '0;
    entry.alu_control = 5'd0;
    if (opcode == OP_LUI) begin
      entry.result      = imm_full;
      entry.alu_control = ALU_LUI;
    end else if (opcode == OP_AUIPC) begin
      entry.result      = ADD_PC ? sum_full : imm_full;
      entry.alu_control = ALU_AUIPC;
    end
  end

endmodule

// File: rtl/decode_upperimm_stage.sv
// -----------------------------------------------------------------------------
// decode_upperimm_stage
// Registered, back-pressurable decode stage for LUI / AUIPC with a two-entry
// skid buffer (main entry M drives the outputs, skid entry S absorbs one word
// when downstream stalls). in_ready is a flop equal to !S.valid, so it has no
// combinational dependence on out_ready.
// Ports:
//   clk, rst_n (async, active low), flush (sync kill of M and S)
//   in_valid / in_ready / in_instr[31:0] / in_pc[XLEN-1:0]   upstream link
//   out_valid / out_ready                                     downstream link
//   out_rd[4:0], out_imm, out_result, out_alu_control[4:0],
//   out_wen, out_illegal                                      decoded payload
// -----------------------------------------------------------------------------
module decode_upperimm_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit ADD_PC = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_alu_control,
  output logic            out_wen,
  output logic            out_illegal
);

  upimm_entry_t dec_entry;
  upimm_entry_t m_q, m_d;
  upimm_entry_t s_q, s_d;
  logic         m_valid_q, m_valid_d;
  logic         s_valid_q, s_valid_d;
  logic         in_ready_q, in_ready_d;
  logic         in_fire;
  logic         out_fire;

  upimm_decode #(
    .XLEN   (XLEN),
    .ADD_PC (ADD_PC)
  ) u_decode (
    .in_instr (in_instr),
    .in_pc    (in_pc),
    .entry    (dec_entry)
  );

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = m_valid_q && out_ready;

  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    if (flush) begin
      // Kills everything; any simultaneous transfer is ignored.
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (s_valid_q) begin
      // in_ready is low here, so only the drain of S into M can happen.
      if (out_fire) begin
        m_d       = s_q;
        s_valid_d = 1'b0;
      end
    end else if (m_valid_q) begin
      if (out_fire) begin
        if (in_fire) begin
          m_d = dec_entry;
        end else begin
          m_valid_d = 1'b0;
        end
      end else if (in_fire) begin
        s_d       = dec_entry;
        s_valid_d = 1'b1;
      end
    end else if (in_fire) begin
      m_d       = dec_entry;
      m_valid_d = 1'b1;
    end
    in_ready_d = !s_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q        <= '0;
      s_q        <= '0;
      m_valid_q  <= 1'b0;
      s_valid_q  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      m_q        <= m_d;
      s_q        <= s_d;
      m_valid_q  <= m_valid_d;
      s_valid_q  <= s_valid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = m_valid_q;
  assign out_rd          = m_q.rd;
  assign out_imm         = m_q.imm[XLEN-1:0];
  assign out_result      = m_q.result[XLEN-1:0];
  assign out_alu_control = m_q.alu_control;
  assign out_wen         = m_q.wen;
  assign out_illegal     = m_q.illegal;

  // Upper storage bits are always zero for narrow XLEN; fold them away.
  if (XLEN < XLEN_MAX) begin : g_hi_unused
    logic unused_hi;
    assign unused_hi = ^{m_q.imm[XLEN_MAX-1:XLEN], m_q.result[XLEN_MAX-1:XLEN]};
  end

endmodule

// File: doc/decode_upperimm_stage.md
Name: decode_upperimm_stage

Overview:
Registered, back-pressurable decode stage for RISC-V upper-immediate instructions (LUI, AUIPC). It is generalised in XLEN and has an optional in-stage AUIPC address add. It sits between fetch and execute on a valid/ready link. A two-entry skid buffer keeps in_ready free of any combinational path from out_ready. Non-U-type opcodes are flagged illegal instead of defaulting to AUIPC.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64.
ADD_PC, 1, 1: out_result = pc + imm for AUIPC; 0: out_result = imm for both opcodes.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all buffered entries
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept; registered
in_instr  input  32  instruction word
in_pc  input  XLEN  PC of in_instr
out_valid  output  1  decoded entry available
out_ready  input  1  downstream accepts
out_rd  output  5  destination register, instr[11:7]
out_imm  output  XLEN  {instr[31:12],12'd0}, sign-extended to XLEN
out_result  output  XLEN  rd writeback value
out_alu_control  output  5  `LUI, `AUIPC, or 5'd0 when illegal
out_wen  output  1  register write enable: !illegal && rd != 0
out_illegal  output  1  opcode is neither OP_LUI nor OP_AUIPC

Behaviour:
- Storage: main entry M (drives outputs) and skid entry S. Each entry holds rd, imm, result, alu_control, wen, illegal and a valid bit.
- Decode is combinational on the input side. An entry is written already decoded, so outputs are pure register outputs.
- Imm: bits [31:12] = instr[31:12], bits [11:0] = 0. When XLEN=64, bits [63:32] = instr[31].
- Result:
  - LUI: out_result = imm.
  - AUIPC: out_result = pc + imm, modulo 2^XLEN (carry discarded). With ADD_PC=0, out_result = imm.
- Illegal entries: out_illegal=1, out_alu_control=0, out_wen=0, out_result=0. rd and imm are still captured as decoded.
- Handshake:
  - Input transfer on in_valid && in_ready.
  - Output transfer on out_valid && out_ready.
  - out_valid = M.valid.
  - out_valid and all out_* payload must hold stable while out_valid && !out_ready.
- in_ready is registered and equals !S.valid. It is 1 after reset.
- Latency and throughput: an accepted instruction appears on the outputs the next cycle if M is empty or draining. Sustained throughput is 1 per cycle.
- Next-state rules for a cycle with an input transfer (in) and/or an output transfer (out):
  - M empty: in loads M.
  - M full, out, S empty: in loads M, or M empties if there is no in.
  - M full, no out, S empty: in loads S; in_ready falls next cycle.
  - S full: out moves S to M and S empties; in is impossible because in_ready=0.
- Ordering is strictly FIFO. No entry is dropped or duplicated.
- Flush:
  - Clears M.valid and S.valid at the edge.
  - Has priority over a simultaneous input or output transfer; the input word is discarded.
  - in_ready=1 the next cycle.
- Reset (asynchronous, any time, including mid-transfer) forces:
  - M.valid=0, S.valid=0, in_ready=1.
  - All payload registers to 0, so out_rd, out_imm, out_result, out_alu_control, out_wen and out_illegal read 0.
  - The first accept is possible on the first rising edge after rst_n deasserts.
- Payload registers load only on their load condition. No X-propagation from an idle in_instr.

Decomposition:
- Shared package riscv_pkg holds:
  - OP_LUI=7'b0110111 and OP_AUIPC=7'b0010111.
  - ALU-control encodings LUI and AUIPC (5 bits), retiring the backtick macros for new code.
  - A packed struct upimm_entry_t {rd, imm, result, alu_control, wen, illegal}, parameterised via XLEN-sized fields.
- Natural sub-module: upimm_decode, the combinational instr+pc -> upimm_entry_t function. The skid logic lives in the top.

Test Plan:
- LUI decode: in_instr=0x12345537, out_ready=1 -> next cycle out_rd=10, out_imm=0x12345000, out_result=0x12345000, out_alu_control=LUI, out_wen=1, out_illegal=0.
- AUIPC, XLEN=64: in_instr=0xFFFFF097, in_pc=0x1000 -> out_imm=0xFFFFFFFFFFFFF000, out_result=0x0, out_rd=1, out_wen=1. With ADD_PC=0 -> out_result=out_imm.
- Illegal opcode: in_instr=0x00000013 (addi) -> out_illegal=1, out_alu_control=0, out_wen=0. Also in_instr=0x00000037 (LUI with rd=0) -> out_illegal=0, out_wen=0.
- Backpressure: push A, B, C back-to-back with out_ready=0 -> A held on outputs, in_ready=0 after B is accepted, C held upstream. Release out_ready -> A, B, C emerge in order, one per cycle, with no gaps once flowing.
- Flush with M and S full, plus in_valid high in the same cycle -> next cycle out_valid=0, in_ready=1, and none of the three entries is ever output.
- Asynchronous reset asserted mid-stream between clock edges -> outputs go to 0 and in_ready=1 immediately, without waiting for a clock edge. After release, the first instruction is decoded with one-cycle latency.
